// File: rtl/syn_tle_drain.sv
// syn_tle_drain: drain stage that takes one M x N matrix of 4P-bit two's complement
// accumulators per valid/ready transfer and streams it out one row per cycle.
// Optional requantization (shift, round half-up, saturate to P bits) is enabled by
// defining D_SERIAL_REQUANT_EN; without it rows carry the raw accumulators.
// Note: rst_ni is asynchronous and active-high despite its name.
module syn_tle_drain #(
    parameter int M   = 8,
    parameter int N   = 4,
    parameter int P   = 8,
    parameter int SHW = $clog2(4 * P),
`ifdef D_SERIAL_REQUANT_EN
    localparam int OW = P,
`else
    localparam int OW = 4 * P,
`endif
    localparam int IW = (M > 1) ? $clog2(M) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [M-1:0][N-1:0][4*P-1:0]  D_i,
    input  logic [SHW-1:0]                shift_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic [N-1:0][OW-1:0]          row_o,
    output logic [IW-1:0]                 row_idx_o,
    output logic                          row_last_o,
    output logic                          row_sat_o,
    output logic                          row_valid_o,
    input  logic                          row_ready_i
);

    typedef enum logic {StIdle, StDrain} state_e;

    state_e                         state_q;
    logic [M-1:0][N-1:0][4*P-1:0]   mat_q;
    logic [IW-1:0]                  idx_q;
    logic                           last;
    logic                           xfer;
    logic                           accept;
    logic [N-1:0][4*P-1:0]          cur_row;

    assign row_valid_o = (state_q == StDrain);
    assign last        = row_valid_o && (idx_q == IW'(M - 1));
    assign xfer        = row_valid_o && row_ready_i;
    // Accept while idle, or in the same cycle the last row leaves (no bubble).
    assign ready_o     = (state_q == StIdle) || (xfer && last);
    assign accept      = valid_i && ready_o;
    assign row_idx_o   = idx_q;
    assign row_last_o  = last;
    assign cur_row     = mat_q[idx_q];

    // Matrix capture and row sequencing.
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            state_q <= StIdle;
            idx_q   <= '0;
            mat_q   <= '0;
        end else if (accept) begin
            mat_q   <= D_i;
            idx_q   <= '0;
            state_q <= StDrain;
        end else if (xfer) begin
            if (last) begin
                state_q <= StIdle;
                idx_q   <= '0;
            end else begin
                idx_q <= idx_q + IW'(1);
            end
        end
    end

`ifdef D_SERIAL_REQUANT_EN
    logic [SHW-1:0]        shift_q;
    logic signed [4*P:0]   ext;
    logic signed [4*P:0]   rnd;
    logic signed [4*P:0]   sum;
    logic signed [4*P:0]   y;

    // Shift amount travels with the matrix it was sampled with.
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            shift_q <= '0;
        end else if (accept) begin
            shift_q <= shift_i;
        end
    end

    // Round half-up, arithmetic shift and saturate each element of the current row.
    always_comb begin
        row_o     = '0;
        row_sat_o = 1'b0;
        ext       = '0;
        rnd       = '0;
        sum       = '0;
        y         = '0;
        if (row_valid_o) begin
            for (int j = 0; j < N; j++) begin
                ext = {cur_row[j][4*P-1], cur_row[j]};
                if (shift_q == '0) begin
                    y = ext;
                end else begin
                    rnd = $signed((4 * P + 1)'(1) << (shift_q - 1'b1));
                    sum = ext + rnd;
                    y   = sum >>> shift_q;
                end
                // Fits in P bits only if all bits from the P-1 sign position up agree.
                if (!(&y[4*P:P-1]) && (|y[4*P:P-1])) begin
                    row_sat_o = 1'b1;
                    row_o[j]  = y[4*P] ? {1'b1, {(P-1){1'b0}}} : {1'b0, {(P-1){1'b1}}};
                end else begin
                    row_o[j] = y[P-1:0];
                end
            end
        end
    end
`else
    logic unused_shift;

    // Raw accumulators pass straight through; zero while no matrix is held.
    always_comb begin
        row_o        = row_valid_o ? cur_row : '0;
        row_sat_o    = 1'b0;
        unused_shift = ^shift_i;
    end
`endif

endmodule
